// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks (uart_baud_rate, uart_rx,
// and later uart_tx).
//   UART_OVERSAMPLE : baud_tick pulses per bit period
//   UART_DATA_BITS  : data bits per 8N1 frame
//   rx_state_t      : receiver FSM states
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line.
// Both flops reset to 1 so that reset looks like an idle (high) line and
// cannot be mistaken for a start bit.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronized output (2 clk latency)
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampling rx on baud_tick (OVERSAMPLE x baud).
// Deframes LSB-first characters and presents them on a valid/ready interface.
//   clk, rst     : system clock, async active-high reset
//   baud_tick    : one-clk pulse at OVERSAMPLE x baud rate
//   rx           : asynchronous serial input, idles high
//   data_out     : last received byte
//   data_valid   : data_out holds an unconsumed byte
//   data_ready   : consumer accepts when data_valid && data_ready
//   frame_error  : one-clk pulse, stop bit sampled low
//   overrun      : one-clk pulse, new byte landed on an unconsumed one
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  // Compared before the increment, so this is the tick that takes bcnt to DATA_BITS.
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic                 rx_s;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;

  logic tcnt_clr, tcnt_inc, bcnt_clr, bcnt_inc, shift_en, load, ferr;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // After the start bit is centred, sampling every OVERSAMPLE ticks lands
  // each data and stop sample mid-bit.
  always_comb begin
    state_n  = state;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    bcnt_clr = 1'b0;
    bcnt_inc = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    ferr     = 1'b0;
    case (state)
      // Start edge is looked for every clk, not only on ticks.
      IDLE: begin
        if (!rx_s) begin
          state_n  = START;
          tcnt_clr = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tcnt == T_MID) begin
            tcnt_clr = 1'b1;
            bcnt_clr = 1'b1;
            state_n  = rx_s ? IDLE : DATA;  // high at mid start bit = glitch
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tcnt == T_LAST) begin
            shift_en = 1'b1;
            tcnt_clr = 1'b1;
            bcnt_inc = 1'b1;
            if (bcnt == B_LAST) state_n = STOP;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tcnt == T_LAST) begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            load    = rx_s;
            ferr    = !rx_s;
            state_n = IDLE;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;

      if (bcnt_clr)      bcnt <= '0;
      else if (bcnt_inc) bcnt <= bcnt + 1'b1;

      // LSB arrives first; right shift leaves it at bit 0 after DATA_BITS shifts.
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

      frame_error <= ferr;
      // A byte consumed in the load cycle is not lost, so no overrun then.
      overrun     <= load && data_valid && !data_ready;

      // Load has priority over the handshake clear.
      if (load) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are driven as whole
// bit periods (64 clk = 16 ticks x 4 clk); expected results come from the
// frame contents (stop high -> byte, stop low -> framing error) and from
// tick counting for exact load timing.
module tb_uart_rx;

  localparam int BIT_CLK    = 64;   // 16 ticks, one tick every 4 clk
  localparam int STOP_TICKS = 152;  // start detect -> stop sample

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_error, overrun;
  logic [1:0] div = 2'd0;

  int n_chk = 0, n_fail = 0;
  int nf = 0, no = 0, nh = 0;          // frame_error / overrun / handshake counts
  logic [8:0] exp_q[$], got_q[$];      // {is_ferr, byte}

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  // Event monitor, sampled well away from both clock edges.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (frame_error) begin nf = nf + 1; got_q.push_back(9'h100); end
      if (overrun) no = no + 1;
      if (data_valid && data_ready) begin nh = nh + 1; got_q.push_back({1'b0, data_out}); end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; stop bit is held low only 44 clk so that the
  // receiver's post-stop start check sees a high line when stop is low.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop;
    repeat (44) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK - 44) @(negedge clk);
  endtask

  // Started at the same negedge as the falling edge of rx. rx_s is low after
  // two posedges, the FSM leaves IDLE on the third, then 152 ticks follow.
  // Returns at the negedge just before the stop-sample posedge.
  task automatic to_stop_tick();
    int cnt;
    cnt = 0;
    repeat (3) @(posedge clk);
    while (cnt < STOP_TICKS) begin
      @(negedge clk);
      if (baud_tick) cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp_q(input string name, input int gb, input int eb);
    chk({name, " count"}, 32'(got_q.size() - gb), 32'(exp_q.size() - eb));
    for (int i = 0; i < exp_q.size() - eb; i++)
      if (gb + i < got_q.size()) chk(name, 32'(got_q[gb+i]), 32'(exp_q[eb+i]));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    int         dh, df, dov;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int bf, bo, bh, gb, eb;
    logic [7:0] rd;
    logic       rs;

    tbl[0] = '{8'h96, 1'b1, 1'b0, 1'b1, 8'h96, 0, 0, 0};
    tbl[1] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h96, 1, 1, 0};  // framing error
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h96, 0, 1, 0};  // break
    tbl[3] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 0, 0, 0};
    tbl[4] = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h34, 0, 0, 1};  // overrun
    tbl[5] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 2, 0, 0};
    tbl[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 8'h7E, 0, 0, 0};

    // Reset state
    idle(3);
    chk("rst data_out", 32'(data_out), 0);
    chk("rst data_valid", 32'(data_valid), 0);
    chk("rst frame_error", 32'(frame_error), 0);
    chk("rst overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(10);

    // Nominal byte with exact load timing, then a one-cycle ready pulse
    fork
      send_frame(8'hA5, 1'b1);
      begin
        to_stop_tick();
        chk("nom valid before load", 32'(data_valid), 0);
        @(negedge clk);
        chk("nom valid at load", 32'(data_valid), 1);
        chk("nom data at load", 32'(data_out), 32'h A5);
      end
    join
    idle(20);
    chk("nom valid held", 32'(data_valid), 1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("nom valid after ready", 32'(data_valid), 0);
    chk("nom data kept", 32'(data_out), 32'hA5);

    // Table: one frame per entry, ready held constant
    for (int k = 0; k < 7; k++) begin
      data_ready = tbl[k].rdy;
      bf = nf; bo = no; bh = nh;
      send_frame(tbl[k].d, tbl[k].stop);
      idle(20);
      chk($sformatf("tbl%0d valid", k), 32'(data_valid), 32'(tbl[k].exp_v));
      chk($sformatf("tbl%0d data", k), 32'(data_out), 32'(tbl[k].exp_d));
      chk($sformatf("tbl%0d ferr", k), 32'(nf - bf), 32'(tbl[k].df));
      chk($sformatf("tbl%0d ovr", k), 32'(no - bo), 32'(tbl[k].dov));
      chk($sformatf("tbl%0d hs", k), 32'(nh - bh), 32'(tbl[k].dh));
    end
    data_ready = 1'b0;

    // Ready asserted exactly in the load cycle: no overrun
    bo = no; bh = nh;
    fork
      send_frame(8'h34, 1'b1);
      begin
        to_stop_tick();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
      end
    join
    idle(20);
    chk("ldrdy ovr", 32'(no - bo), 0);
    chk("ldrdy hs", 32'(nh - bh), 1);
    chk("ldrdy valid", 32'(data_valid), 1);
    chk("ldrdy data", 32'(data_out), 32'h34);

    // False start: 3 ticks low
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    idle(4);
    bf = nf; bo = no; bh = nh;
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(80);
    chk("fs ferr", 32'(nf - bf), 0);
    chk("fs ovr", 32'(no - bo), 0);
    chk("fs valid", 32'(data_valid), 0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    chk("fs next valid", 32'(data_valid), 1);
    chk("fs next data", 32'(data_out), 32'h3C);
    chk("fs next ferr", 32'(nf - bf), 0);

    // Back-to-back frames, ready held high
    data_ready = 1'b1;
    idle(2);
    gb = got_q.size(); eb = exp_q.size();
    foreach (tbl[k]) if (k < 3) begin end  // keep loop vars local
    exp_q.push_back(9'h000); send_frame(8'h00, 1'b1);
    exp_q.push_back(9'h0FF); send_frame(8'hFF, 1'b1);
    exp_q.push_back(9'h081); send_frame(8'h81, 1'b1);
    idle(20);
    cmp_q("b2b", gb, eb);

    // Reset mid-frame during data bit 3 of 0xF0
    data_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(10);
    bf = nf; bo = no;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(BIT_CLK * 4 + BIT_CLK / 2);
        rst = 1'b1;
        #1;
        chk("mrst data_out", 32'(data_out), 0);
        chk("mrst data_valid", 32'(data_valid), 0);
        chk("mrst frame_error", 32'(frame_error), 0);
        chk("mrst overrun", 32'(overrun), 0);
      end
    join
    idle(5);
    rst = 1'b0;
    idle(20);
    chk("mrst no partial", 32'(data_valid), 0);
    chk("mrst no pulses", 32'((nf - bf) + (no - bo)), 0);
    send_frame(8'h0F, 1'b1);
    idle(20);
    chk("mrst next valid", 32'(data_valid), 1);
    chk("mrst next data", 32'(data_out), 32'h0F);

    // Random frames against the frame-level model
    data_ready = 1'b1;
    idle(2);
    gb = got_q.size(); eb = exp_q.size();
    for (int k = 0; k < 24; k++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      exp_q.push_back(rs ? {1'b0, rd} : 9'h100);
      send_frame(rd, rs);
      idle(rs ? $urandom_range(0, 40) : 20 + $urandom_range(0, 40));
    end
    idle(40);
    cmp_q("rand", gb, eb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
